// File: rtl/ram_arbiter.sv
// Two-master valid/ready front end for one single-port synchronous RAM; read data returns 2 cycles after accept.
// One accept per cycle, no RAM backpressure; the losing or locked-out port simply sees ready=0.
module ram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              ram_ena,
  output logic              ram_rd,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {LOCK_NONE, LOCK_P0, LOCK_P1} lock_e;

  typedef struct packed {
    logic              ena;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } cmd_t;

  lock_e             lock_owner_q, lock_owner_d;
  logic              last_grant_q, last_grant_d;
  cmd_t              cmd_q, cmd_d;
  logic              tag1_vld_q, tag1_vld_d;
  logic              tag1_port_q, tag1_port_d;
  logic              tag2_vld_q, tag2_vld_d;
  logic              tag2_port_q, tag2_port_d;

  logic              elig0, elig1;
  logic              grant0, grant1;
  logic              accept, win_port;
  logic              sel_we, sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    elig0 = req0_valid && (lock_owner_q != LOCK_P1);
    elig1 = req1_valid && (lock_owner_q != LOCK_P0);
    // last_grant_q == 1 means port 1 won last time, so port 0 takes the next contention
    if (elig0 && elig1) begin
      grant0 = (FIXED_PRIO != 0) || last_grant_q;
    end else begin
      grant0 = elig0;
    end
    grant1    = elig1 && !grant0;
    accept    = grant0 || grant1;
    win_port  = grant1;
    sel_we    = win_port ? req1_we    : req0_we;
    sel_lock  = win_port ? req1_lock  : req0_lock;
    sel_addr  = win_port ? req1_addr  : req0_addr;
    sel_wdata = win_port ? req1_wdata : req0_wdata;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    lock_owner_d = lock_owner_q;
    cmd_d        = cmd_q;
    cmd_d.ena    = 1'b0;
    cmd_d.rd     = 1'b0;
    cmd_d.wr     = 1'b0;
    tag1_vld_d   = 1'b0;
    tag1_port_d  = tag1_port_q;
    if (accept) begin
      last_grant_d = win_port;
      // an unlocking beat can only come from the owner or from a port while nobody owns the lock
      if (sel_lock) begin
        lock_owner_d = win_port ? LOCK_P1 : LOCK_P0;
      end else begin
        lock_owner_d = LOCK_NONE;
      end
      cmd_d.ena   = 1'b1;
      cmd_d.rd    = !sel_we;
      cmd_d.wr    = sel_we;
      cmd_d.addr  = sel_addr;
      cmd_d.din   = sel_wdata;
      tag1_vld_d  = !sel_we;
      tag1_port_d = win_port;
    end
    tag2_vld_d  = tag1_vld_q;
    tag2_port_d = tag1_port_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      lock_owner_q <= LOCK_NONE;
      cmd_q        <= '0;
      tag1_vld_q   <= 1'b0;
      tag1_port_q  <= 1'b0;
      tag2_vld_q   <= 1'b0;
      tag2_port_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_owner_q <= lock_owner_d;
      cmd_q        <= cmd_d;
      tag1_vld_q   <= tag1_vld_d;
      tag1_port_q  <= tag1_port_d;
      tag2_vld_q   <= tag2_vld_d;
      tag2_port_q  <= tag2_port_d;
    end
  end

  // ready is forced low while reset is held so no beat looks accepted during reset
  always_comb begin
    req0_ready  = grant0 && rst_n;
    req1_ready  = grant1 && rst_n;
    req0_rvalid = tag2_vld_q && !tag2_port_q;
    req1_rvalid = tag2_vld_q && tag2_port_q;
    req0_rdata  = ram_dout;
    req1_rdata  = ram_dout;
    ram_ena     = cmd_q.ena;
    ram_rd      = cmd_q.rd;
    ram_wr      = cmd_q.wr;
    ram_addr    = cmd_q.addr;
    ram_din     = cmd_q.din;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: round-robin and fixed-priority instances, each with its own RAM,
// checked every cycle against an acceptance-order model, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // stimulus arrays indexed [instance][port]; instance 0 = round-robin, 1 = fixed priority
  logic        v  [2][2];
  logic        we [2][2];
  logic        lk [2][2];
  logic [15:0] ad [2][2];
  logic [7:0]  wd [2][2];

  logic        rdy0_a, rdy1_a, rv0_a, rv1_a, ena_a, rds_a, wrs_a;
  logic [7:0]  rd0_a, rd1_a, din_a, dout_a;
  logic [15:0] addr_a;
  logic        rdy0_b, rdy1_b, rv0_b, rv1_b, ena_b, rds_b, wrs_b;
  logic [7:0]  rd0_b, rd1_b, din_b, dout_b;
  logic [15:0] addr_b;

  ram_arbiter #(.ADDR_W(16), .DATA_W(8), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0][0]), .req0_we(we[0][0]), .req0_lock(lk[0][0]), .req0_addr(ad[0][0]),
    .req0_wdata(wd[0][0]), .req0_ready(rdy0_a), .req0_rvalid(rv0_a), .req0_rdata(rd0_a),
    .req1_valid(v[0][1]), .req1_we(we[0][1]), .req1_lock(lk[0][1]), .req1_addr(ad[0][1]),
    .req1_wdata(wd[0][1]), .req1_ready(rdy1_a), .req1_rvalid(rv1_a), .req1_rdata(rd1_a),
    .ram_ena(ena_a), .ram_rd(rds_a), .ram_wr(wrs_a), .ram_addr(addr_a), .ram_din(din_a),
    .ram_dout(dout_a)
  );

  ram_arbiter #(.ADDR_W(16), .DATA_W(8), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[1][0]), .req0_we(we[1][0]), .req0_lock(lk[1][0]), .req0_addr(ad[1][0]),
    .req0_wdata(wd[1][0]), .req0_ready(rdy0_b), .req0_rvalid(rv0_b), .req0_rdata(rd0_b),
    .req1_valid(v[1][1]), .req1_we(we[1][1]), .req1_lock(lk[1][1]), .req1_addr(ad[1][1]),
    .req1_wdata(wd[1][1]), .req1_ready(rdy1_b), .req1_rvalid(rv1_b), .req1_rdata(rd1_b),
    .ram_ena(ena_b), .ram_rd(rds_b), .ram_wr(wrs_b), .ram_addr(addr_b), .ram_din(din_b),
    .ram_dout(dout_b)
  );

  // single-port synchronous RAMs with registered read data
  logic [7:0] mem_a [65536];
  logic [7:0] mem_b [65536];
  always @(posedge clk) begin
    if (ena_a) begin
      if (wrs_a) mem_a[addr_a] <= din_a;
      if (rds_a) dout_a <= mem_a[addr_a];
    end
  end
  always @(posedge clk) begin
    if (ena_b) begin
      if (wrs_b) mem_b[addr_b] <= din_b;
      if (rds_b) dout_b <= mem_b[addr_b];
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL [%s] %s @%0t: got %0h, expected %0h", (inst == 0) ? "rr" : "fp", nm, $time, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rdy0, rdy1, rv0, rv1;
    logic [7:0]  rd0, rd1;
    logic        ena, rds, wrs;
    logic [15:0] addr;
    logic [7:0]  din;
  } obs_t;

  function automatic obs_t obs(input int i);
    obs_t o;
    if (i == 0) begin
      o.rdy0 = rdy0_a; o.rdy1 = rdy1_a; o.rv0 = rv0_a; o.rv1 = rv1_a;
      o.rd0 = rd0_a; o.rd1 = rd1_a; o.ena = ena_a; o.rds = rds_a; o.wrs = wrs_a;
      o.addr = addr_a; o.din = din_a;
    end else begin
      o.rdy0 = rdy0_b; o.rdy1 = rdy1_b; o.rv0 = rv0_b; o.rv1 = rv1_b;
      o.rd0 = rd0_b; o.rd1 = rd1_b; o.ena = ena_b; o.rds = rds_b; o.wrs = wrs_b;
      o.addr = addr_b; o.din = din_b;
    end
    return o;
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    int         inst;
    int         due;
    int         port;
    logic [7:0] data;
  } resp_t;

  resp_t       rq[$];
  int          cyc = 0;
  int          lock_own [2];   // -1 none, else owning port
  int          last     [2];
  logic        e_ena [2], e_rd [2], e_wr [2];
  logic [15:0] e_addr [2];
  logic [7:0]  e_din  [2];
  logic [7:0]  mmem [2][65536];
  logic        acc  [2][2];

  task automatic model_cycle(input int i);
    obs_t       o;
    int         g;
    bit         e0, e1;
    bit         xv [2];
    logic [7:0] xd [2];
    o  = obs(i);
    xv = '{0, 0};
    xd = '{8'h00, 8'h00};
    if (!rst_n) begin
      chk(i, "reset_outputs", 32'({o.rdy0, o.rdy1, o.rv0, o.rv1, o.ena, o.rds, o.wrs, o.addr, o.din}), 32'(0));
      lock_own[i] = -1;
      last[i]     = 1;
      e_ena[i] = 1'b0; e_rd[i] = 1'b0; e_wr[i] = 1'b0; e_addr[i] = '0; e_din[i] = '0;
      acc[i][0] = 1'b0; acc[i][1] = 1'b0;
      for (int k = rq.size() - 1; k >= 0; k--) if (rq[k].inst == i) rq.delete(k);
      return;
    end
    e0 = v[i][0] && (lock_own[i] != 1);
    e1 = v[i][1] && (lock_own[i] != 0);
    if (e0 && e1) g = (i == 1) ? 0 : 1 - last[i];
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    else          g = -1;
    chk(i, "ready0", 32'(o.rdy0), 32'(g == 0));
    chk(i, "ready1", 32'(o.rdy1), 32'(g == 1));
    chk(i, "ram_cmd", 32'({o.ena, o.rds, o.wrs, o.addr, o.din}),
        32'({e_ena[i], e_rd[i], e_wr[i], e_addr[i], e_din[i]}));
    foreach (rq[k]) begin
      if (rq[k].inst == i && rq[k].due == cyc) begin
        xv[rq[k].port] = 1'b1;
        xd[rq[k].port] = rq[k].data;
      end
    end
    for (int k = rq.size() - 1; k >= 0; k--) if (rq[k].inst == i && rq[k].due <= cyc) rq.delete(k);
    chk(i, "rvalid0", 32'(o.rv0), 32'(xv[0]));
    chk(i, "rvalid1", 32'(o.rv1), 32'(xv[1]));
    if (xv[0]) chk(i, "rdata0", 32'(o.rd0), 32'(xd[0]));
    if (xv[1]) chk(i, "rdata1", 32'(o.rd1), 32'(xd[1]));
    acc[i][0] = v[i][0] && o.rdy0;
    acc[i][1] = v[i][1] && o.rdy1;
    e_ena[i] = 1'b0; e_rd[i] = 1'b0; e_wr[i] = 1'b0;
    if (g >= 0) begin
      last[i]     = g;
      lock_own[i] = lk[i][g] ? g : -1;
      e_ena[i]  = 1'b1;
      e_rd[i]   = !we[i][g];
      e_wr[i]   = we[i][g];
      e_addr[i] = ad[i][g];
      e_din[i]  = wd[i][g];
      if (we[i][g]) mmem[i][ad[i][g]] = wd[i][g];
      else rq.push_back('{inst: i, due: cyc + 2, port: g, data: mmem[i][ad[i][g]]});
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    model_cycle(0);
    model_cycle(1);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input int p, input logic vv, input logic w, input logic l,
                     input logic [15:0] a, input logic [7:0] d);
    v[i][p] = vv; we[i][p] = w; lk[i][p] = l; ad[i][p] = a; wd[i][p] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int na [2];
    int g0, g1;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) put(i, p, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
    rst_n = 1'b0;
    put(0, 0, 1'b1, 1'b0, 1'b0, 16'h0, 8'h0);
    @(negedge clk);
    chk(0, "reset_ready0", 32'(rdy0_a), 32'(0));
    chk(0, "reset_ena", 32'(ena_a), 32'(0));
    chk(1, "reset_rvalid0", 32'(rv0_b), 32'(0));
    step(); step();
    v[0][0] = 1'b0;
    rst_n = 1'b1;

    // known contents for every address the bench will ever read
    for (int a = 0; a < 64; a++) begin
      put(0, 0, 1'b1, 1'b1, 1'b0, 16'(a), 8'(a * 7 + 3));
      put(1, 0, 1'b1, 1'b1, 1'b0, 16'(a), 8'(a * 5 + 1));
      step();
    end
    v[0][0] = 1'b0; v[1][0] = 1'b0;
    step();

    // single read
    put(0, 0, 1'b1, 1'b1, 1'b0, 16'h0010, 8'hA5);
    step();
    put(0, 0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
    @(negedge clk);
    chk(0, "A_accept", 32'(rdy0_a), 32'(1));
    step();
    v[0][0] = 1'b0;
    @(negedge clk);
    chk(0, "A_ram_rd", 32'(rds_a), 32'(1));
    chk(0, "A_ram_addr", 32'(addr_a), 32'(16'h0010));
    step();
    @(negedge clk);
    chk(0, "A_rvalid0", 32'(rv0_a), 32'(1));
    chk(0, "A_rdata0", 32'(rd0_a), 32'(8'hA5));
    chk(0, "A_rvalid1", 32'(rv1_a), 32'(0));
    step();

    // write then read on port 1
    put(0, 1, 1'b1, 1'b1, 1'b0, 16'h1234, 8'h3C);
    @(negedge clk);
    chk(0, "B_wr_accept", 32'(rdy1_a), 32'(1));
    step();
    put(0, 1, 1'b1, 1'b0, 1'b0, 16'h1234, 8'h00);
    @(negedge clk);
    chk(0, "B_rd_accept", 32'(rdy1_a), 32'(1));
    step();
    v[0][1] = 1'b0;
    @(negedge clk);
    chk(0, "B_no_wr_resp", 32'(rv1_a), 32'(0));
    step();
    @(negedge clk);
    chk(0, "B_rvalid1", 32'(rv1_a), 32'(1));
    chk(0, "B_rdata1", 32'(rd1_a), 32'(8'h3C));
    step();

    // round-robin contention: port 1 won last, so grants alternate starting at port 0
    na = '{0, 0};
    g0 = 0; g1 = 0;
    put(0, 0, 1'b1, 1'b0, 1'b0, 16'd8, 8'h0);
    put(0, 1, 1'b1, 1'b0, 1'b0, 16'd9, 8'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 6) begin
        chk(0, "C_grant0", 32'(rdy0_a), 32'(k % 2 == 0));
        chk(0, "C_grant1", 32'(rdy1_a), 32'(k % 2 == 1));
      end
      if (rv0_a) g0++;
      if (rv1_a) g1++;
      step();
      for (int p = 0; p < 2; p++) begin
        if (acc[0][p]) begin
          na[p]++;
          ad[0][p] = ad[0][p] + 16'd2;
          if (na[p] == 3) v[0][p] = 1'b0;
        end
      end
    end
    chk(0, "C_rvalid_count0", 32'(g0), 32'(3));
    chk(0, "C_rvalid_count1", 32'(g1), 32'(3));

    // fixed priority
    put(1, 0, 1'b1, 1'b0, 1'b0, 16'd20, 8'h0);
    put(1, 1, 1'b1, 1'b0, 1'b0, 16'd21, 8'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk(1, "D_ready0", 32'(rdy0_b), 32'(1));
      chk(1, "D_ready1_low", 32'(rdy1_b), 32'(0));
      step();
      ad[1][0] = 16'(22 + k);
    end
    v[1][0] = 1'b0;
    @(negedge clk);
    chk(1, "D_port1_wins", 32'(rdy1_b), 32'(1));
    step();
    v[1][1] = 1'b0;
    step(); step();

    // locked read-modify-write by port 1 while port 0 waits
    put(0, 1, 1'b1, 1'b0, 1'b1, 16'h0020, 8'h00);
    @(negedge clk);
    chk(0, "E_lock_rd", 32'(rdy1_a), 32'(1));
    step();
    v[0][1] = 1'b0;
    put(0, 0, 1'b1, 1'b0, 1'b0, 16'h0020, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk(0, "E_blocked", 32'(rdy0_a), 32'(0));
      step();
    end
    put(0, 1, 1'b1, 1'b1, 1'b0, 16'h0020, 8'h21);
    @(negedge clk);
    chk(0, "E_unlock_wr", 32'(rdy1_a), 32'(1));
    chk(0, "E_blocked_wr", 32'(rdy0_a), 32'(0));
    step();
    v[0][1] = 1'b0;
    @(negedge clk);
    chk(0, "E_p0_go", 32'(rdy0_a), 32'(1));
    step();
    v[0][0] = 1'b0;
    step();
    @(negedge clk);
    chk(0, "E_rvalid0", 32'(rv0_a), 32'(1));
    chk(0, "E_rdata0", 32'(rd0_a), 32'(8'h21));
    step();

    // reset with a read in flight
    put(0, 0, 1'b1, 1'b0, 1'b0, 16'h0010, 8'h00);
    @(negedge clk);
    chk(0, "F_accept", 32'(rdy0_a), 32'(1));
    step();
    rst_n = 1'b0;
    put(0, 0, 1'b1, 1'b1, 1'b0, 16'h0030, 8'h77);
    put(0, 1, 1'b1, 1'b1, 1'b0, 16'h0031, 8'h88);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk(0, "F_rst_ready0", 32'(rdy0_a), 32'(0));
      chk(0, "F_rst_ready1", 32'(rdy1_a), 32'(0));
      chk(0, "F_rst_rvalid0", 32'(rv0_a), 32'(0));
      chk(0, "F_rst_ena", 32'(ena_a), 32'(0));
      step();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk(0, "F_first_grant0", 32'(rdy0_a), 32'(1));
    chk(0, "F_first_grant1", 32'(rdy1_a), 32'(0));
    step();
    v[0][0] = 1'b0;
    @(negedge clk);
    chk(0, "F_then_port1", 32'(rdy1_a), 32'(1));
    step();
    v[0][1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(0, "F_no_rvalid0", 32'(rv0_a), 32'(0));
      chk(0, "F_no_rvalid1", 32'(rv1_a), 32'(0));
      step();
    end

    // randomized traffic on both instances, honouring the hold-while-stalled rule
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (!(v[i][p] && !acc[i][p])) begin
            if ($urandom_range(0, 9) < 6)
              put(i, p, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                  16'($urandom_range(0, 63)), 8'($urandom));
            else
              v[i][p] = 1'b0;
          end
        end
      end
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      step();
    end
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) v[i][p] = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
